// File: rtl/peak_report_collector.sv
// Pairs the final I and Q peak of each frame into one AXI-Stream report beat.
// Define PEAK_REPORT_TIMEOUT_EN to discard a half-captured pair after TIMEOUT_CYCLES.
//
// state | meaning
// IDLE  | no channel captured
// PART  | exactly one channel captured, waiting for the other
// FULL  | both channels captured, report waiting for the output slot
module peak_report_collector #(
   parameter int DATA_LEN       = 64,
   parameter int DROP_CNT_WIDTH = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                      clk,
   input  logic                      aresetn,
   input  logic [31:0]               peak_index_i,
   input  logic [31:0]               peak_index_q,
   input  logic [DATA_LEN-1:0]       peak_tdata_i,
   input  logic [DATA_LEN-1:0]       peak_tdata_q,
   input  logic                      peak_tvalid_i,
   input  logic                      peak_tvalid_q,
   input  logic                      peak_tlast_i,
   input  logic                      peak_tlast_q,
   input  logic [31:0]               num_peaks_i,
   input  logic [31:0]               num_peaks_q,
   output logic [2*DATA_LEN+127:0]   m_axis_tdata,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_tready,
   output logic [DROP_CNT_WIDTH-1:0] dropped_reports
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PART = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic                      have_i_q, have_i_d;
   logic                      have_q_q, have_q_d;
   logic [31:0]               idx_i_q, idx_q_q;
   logic [31:0]               num_i_q, num_q_q;
   logic [DATA_LEN-1:0]       val_i_q, val_q_q;
   logic [2*DATA_LEN+127:0]   tdata_q;
   logic                      tvalid_q;
   logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
   logic [DROP_CNT_WIDTH:0]   drop_sum;
   logic [1:0]                drop_inc;
   logic                      cap_i, cap_q, load, tmo_fire, ovr_i, ovr_q;

   if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   assign cap_i = peak_tvalid_i & peak_tlast_i;
   assign cap_q = peak_tvalid_q & peak_tlast_q;
   assign load  = (state_q == FULL) & (~tvalid_q | m_axis_tready);

   // A capture landing on the edge that empties its channel is a fresh frame, not a drop.
   assign ovr_i = cap_i & have_i_q & ~load;
   assign ovr_q = cap_q & have_q_q & ~load;

`ifdef PEAK_REPORT_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt_q;

   assign tmo_fire = (state_q == PART) & ~cap_i & ~cap_q &
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         tmo_cnt_q <= '0;
      end else if (state_q != PART || state_d != PART) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      end
   end
`else
   assign tmo_fire = 1'b0;
`endif

   always_comb begin
      have_i_d = have_i_q;
      have_q_d = have_q_q;
      if (load || tmo_fire) begin
         have_i_d = 1'b0;
         have_q_d = 1'b0;
      end
      if (cap_i) have_i_d = 1'b1;
      if (cap_q) have_q_d = 1'b1;
   end

   always_comb begin
      state_d = IDLE;
      if (have_i_d && have_q_d) begin
         state_d = FULL;
      end else if (have_i_d || have_q_d) begin
         state_d = PART;
      end
   end

   always_comb begin
      drop_inc = 2'(ovr_i) + 2'(ovr_q) + 2'(tmo_fire);
      drop_sum = {1'b0, drop_q} + (DROP_CNT_WIDTH + 1)'(drop_inc);
      drop_d   = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         have_i_q <= 1'b0;
         have_q_q <= 1'b0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         have_i_q <= have_i_d;
         have_q_q <= have_q_d;
         drop_q   <= drop_d;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         idx_i_q <= '0;
         val_i_q <= '0;
         num_i_q <= '0;
      end else if (cap_i) begin
         idx_i_q <= peak_index_i;
         val_i_q <= peak_tdata_i;
         num_i_q <= num_peaks_i;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         idx_q_q <= '0;
         val_q_q <= '0;
         num_q_q <= '0;
      end else if (cap_q) begin
         idx_q_q <= peak_index_q;
         val_q_q <= peak_tdata_q;
         num_q_q <= num_peaks_q;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
      end else if (load) begin
         tdata_q  <= {num_i_q, num_q_q, val_i_q, val_q_q, idx_i_q, idx_q_q};
         tvalid_q <= 1'b1;
      end else if (m_axis_tready) begin
         tvalid_q <= 1'b0;
      end
   end

   assign m_axis_tdata    = tdata_q;
   assign m_axis_tvalid   = tvalid_q;
   assign m_axis_tlast    = tvalid_q;
   assign dropped_reports = drop_q;

endmodule
